// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one UART_tx among NUM_REQ
// requesters. Each granted 16-bit word is sent as two bytes, high byte first.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transfer; arbitrate among pending requests each cycle
// SEND_HI | trmt strobe with the high byte; gnt pulse visible this cycle
// WAIT_HI | high byte in flight; wait for a tx_done rising edge
// SEND_LO | trmt strobe with the low byte
// WAIT_LO | low byte in flight; a tx_done rising edge issues done[owner]
module uart_tx_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    input  logic                  tx_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEND_HI = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] SEND_LO = 3'd3;
    localparam logic [2:0] WAIT_LO = 3'd4;

    logic [2:0]         state;
    logic [15:0]        word;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               tx_done_q;

    logic [NUM_REQ-1:0] mask_hi;
    logic [NUM_REQ-1:0] req_hi;
    logic [PTR_W-1:0]   arb_win;
    logic [15:0]        arb_word;
    logic               tx_rise;

    // Only a fresh rising edge of tx_done counts; a level left over from the
    // previous byte must not advance a WAIT state.
    assign tx_rise = tx_done & ~tx_done_q;

    // Strobes and busy come straight from the state register.
    assign trmt = (state == SEND_HI) || (state == SEND_LO);
    assign busy = (state != IDLE);

    // Round-robin pick: lowest set request at or above the pointer, otherwise
    // wrap around to the lowest set request overall.
    always_comb begin
        mask_hi  = '0;
        arb_win  = '0;
        arb_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_hi[i] = (PTR_W'(i) >= ptr);
        end
        req_hi = req & mask_hi;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_hi != '0) begin
                if (req_hi[i]) arb_win = PTR_W'(i);
            end else begin
                if (req[i]) arb_win = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == arb_win) arb_word = req_data[16*i +: 16];
        end
    end

    // Sequencer FSM with registered gnt/done pulses and byte register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word      <= 16'h0000;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            done      <= '0;
            tx_data   <= 8'h00;
            tx_done_q <= 1'b0;
        end else begin
            gnt       <= '0;
            done      <= '0;
            tx_done_q <= tx_done;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        word    <= arb_word;
                        owner   <= arb_win;
                        ptr     <= (arb_win == LAST_IDX) ? '0 : arb_win + PTR_W'(1);
                        gnt     <= ONE_HOT0 << arb_win;
                        tx_data <= arb_word[15:8];
                        state   <= SEND_HI;
                    end
                end
                SEND_HI: state <= WAIT_HI;
                WAIT_HI: begin
                    if (tx_rise) begin
                        tx_data <= word[7:0];
                        state   <= SEND_LO;
                    end
                end
                SEND_LO: state <= WAIT_LO;
                WAIT_LO: begin
                    if (tx_rise) begin
                        done  <= ONE_HOT0 << owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a simple UART_tx behavioural model.
module tb_uart_tx_arb;

    localparam int N        = 4;
    localparam int BYTE_CYC = 5;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [16*N-1:0] req_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          busy;
    logic          trmt;
    logic [7:0]    tx_data;
    logic          tx_done;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] words [N];
    logic [N-1:0] hold_mask;
    logic        auto_uart;
    int          byte_q[$];
    int          gnt_q[$];
    int          done_q[$];
    int          exp_q[$];

    uart_tx_arb #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_q(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_word(input int i, input logic [15:0] w);
        words[i] = w;
        req_data[16*i +: 16] = w;
    endtask

    task automatic clear_logs();
        byte_q.delete();
        gnt_q.delete();
        done_q.delete();
    endtask

    task automatic wait_dones(input string tag, input int n);
        int cyc = 0;
        while (done_q.size() < n && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        check({tag, "_timeout"}, done_q.size(), n);
        tick(2);
    endtask

    // UART_tx model plus protocol monitor, acting on the falling edge.
    initial begin
        int cnt = 0;
        int w;
        logic prev_trmt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_trmt = 1'b0;
            end else begin
                if (trmt) begin
                    check("trmt_gap", prev_trmt, 0);
                    byte_q.push_back(int'(tx_data));
                    if (auto_uart) begin
                        tx_done = 1'b0;
                        cnt = BYTE_CYC;
                    end
                end else if (auto_uart && cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_done = 1'b1;
                end
                if (gnt != '0) begin
                    w = idx_of(gnt);
                    check("gnt_onehot", $onehot(gnt), 1);
                    check("gnt_trmt", trmt, 1);
                    check("gnt_hi_byte", tx_data, words[w][15:8]);
                    gnt_q.push_back(w);
                    if (!hold_mask[w]) req[w] = 1'b0;
                end
                if (done != '0) begin
                    check("done_onehot", $onehot(done), 1);
                    check("done_busy", busy, 0);
                    done_q.push_back(idx_of(done));
                end
                prev_trmt = trmt;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        auto_uart = 1'b1;
        hold_mask = '0;
        for (int i = 0; i < N; i++) words[i] = 16'h0000;

        // Reset state
        tick(2);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_trmt", trmt, 0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        tick(2);

        // 1: single request, grant and trmt one cycle after req sampled
        clear_logs();
        set_word(0, 16'hA55A);
        req = 4'b0001;
        tick(1);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_trmt", trmt, 1);
        check("t1_tx_data", tx_data, 8'hA5);
        check("t1_busy", busy, 1);
        tick(1);
        check("t1_trmt_off", trmt, 0);
        check("t1_hold_hi", tx_data, 8'hA5);
        wait_dones("t1", 1);
        check("t1_busy_after", busy, 0);
        exp_q = '{8'hA5, 8'h5A};
        compare_q("t1_bytes", byte_q, exp_q);
        exp_q = '{0};
        compare_q("t1_done", done_q, exp_q);

        // 2: four simultaneous requests after reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        clear_logs();
        set_word(0, 16'h1111);
        set_word(1, 16'h2222);
        set_word(2, 16'h3333);
        set_word(3, 16'h4444);
        req = 4'b1111;
        wait_dones("t2", 4);
        exp_q = '{0, 1, 2, 3};
        compare_q("t2_gnt", gnt_q, exp_q);
        compare_q("t2_done", done_q, exp_q);
        exp_q = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        compare_q("t2_bytes", byte_q, exp_q);

        // 3: fairness after serving requester 1
        clear_logs();
        set_word(1, 16'h0102);
        req = 4'b0010;
        wait_dones("t3a", 1);
        set_word(0, 16'h0A0B);
        set_word(2, 16'h0C0D);
        req = 4'b0101;
        wait_dones("t3b", 3);
        exp_q = '{1, 2, 0};
        compare_q("t3_gnt", gnt_q, exp_q);
        exp_q = '{8'h01, 8'h02, 8'h0C, 8'h0D, 8'h0A, 8'h0B};
        compare_q("t3_bytes", byte_q, exp_q);

        // 4: req[3] held continuously, req[1] pulses once
        clear_logs();
        set_word(1, 16'h5566);
        set_word(3, 16'h7788);
        hold_mask = 4'b1000;
        req = 4'b1000;
        begin
            int cyc = 0;
            while (gnt_q.size() < 1 && cyc < 200) begin tick(1); cyc++; end
        end
        req[1] = 1'b1;
        begin
            int cyc = 0;
            while (gnt_q.size() < 3 && cyc < 500) begin tick(1); cyc++; end
        end
        req[3] = 1'b0;
        hold_mask = '0;
        wait_dones("t4", 3);
        exp_q = '{3, 1, 3};
        compare_q("t4_gnt", gnt_q, exp_q);
        compare_q("t4_done", done_q, exp_q);

        // 5: stale tx_done level must not advance WAIT_HI
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_logs();
        auto_uart = 1'b0;
        tx_done = 1'b1;
        tick(3);
        set_word(0, 16'h1234);
        req = 4'b0001;
        tick(1);
        check("t5_trmt_hi", trmt, 1);
        check("t5_tx_hi", tx_data, 8'h12);
        tick(4);
        check("t5_stale_trmt", trmt, 0);
        check("t5_stale_bytes", byte_q.size(), 1);
        check("t5_stale_data", tx_data, 8'h12);
        tx_done = 1'b0;
        tick(2);
        check("t5_low_bytes", byte_q.size(), 1);
        tx_done = 1'b1;
        tick(1);
        check("t5_trmt_lo", trmt, 1);
        check("t5_tx_lo", tx_data, 8'h34);
        tick(3);
        check("t5_no_early_done", done_q.size(), 0);
        tx_done = 1'b0;
        tick(2);
        tx_done = 1'b1;
        auto_uart = 1'b1;
        wait_dones("t5", 1);
        exp_q = '{8'h12, 8'h34};
        compare_q("t5_bytes", byte_q, exp_q);

        // 6: reset during WAIT_LO aborts without a done pulse
        clear_logs();
        set_word(0, 16'hCAFE);
        req = 4'b0001;
        begin
            int cyc = 0;
            while (byte_q.size() < 2 && cyc < 200) begin tick(1); cyc++; end
        end
        tick(1);
        check("t6_in_wait_lo", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_trmt", trmt, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_done", done, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("t6_no_done", done_q.size(), 0);
        clear_logs();
        set_word(2, 16'hBEEF);
        req = 4'b0100;
        wait_dones("t6", 1);
        exp_q = '{2};
        compare_q("t6_gnt", gnt_q, exp_q);
        compare_q("t6_done", done_q, exp_q);
        exp_q = '{8'hBE, 8'hEF};
        compare_q("t6_bytes", byte_q, exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
